// File: rtl/imem_loader.sv
// imem_loader: streams a program byte-by-byte into an instruction RAM.
//
// The loader assembles four accepted bytes big-endian into one 32-bit word
// and writes it to word index 0, 1, 2 ... until the requested number of
// words has been written. The CPU is held while the load runs.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       begin a new session (honoured only when idle or done)
//   word_count  words to load, latched on an accepted start (clamped to 1024)
//   byte_valid  byte_data carries a valid byte
//   byte_data   program byte stream
//   byte_ready  loader accepts a byte this cycle
//   ena, wena   instruction-RAM enable / write enable (one-cycle write pulse)
//   rena        instruction-RAM read enable (never used, tied low)
//   addr        instruction-RAM word index, 0..1023
//   data_in     word to write
//   busy        session in progress
//   done        session complete, held until the next accepted start or reset
//   cpu_stall   holds the CPU/PC, equal to busy
module imem_loader (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [10:0] word_count,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        ena,
   output logic        wena,
   output logic        rena,
   output logic [31:0] addr,
   output logic [31:0] data_in,
   output logic        busy,
   output logic        done,
   output logic        cpu_stall
);

   localparam logic [10:0] MaxWords = 11'd1024;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StWrite,
      StDone
   } state_e;

   state_e      state_q, state_d;
   logic [9:0]  word_cnt_q, word_cnt_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [10:0] n_q, n_d;
   logic [31:0] word_q, word_d;

   logic [10:0] n_clamped;
   logic [10:0] words_written;
   logic        byte_fire;

   assign n_clamped     = (word_count > MaxWords) ? MaxWords : word_count;
   // Includes the word being written in the current WRITE cycle.
   assign words_written = {1'b0, word_cnt_q} + 11'd1;
   assign byte_fire     = byte_valid && (state_q == StLoad);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         word_cnt_q <= '0;
         byte_cnt_q <= '0;
         n_q        <= '0;
         word_q     <= '0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         n_q        <= n_d;
         word_q     <= word_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      byte_cnt_d = byte_cnt_q;
      n_d        = n_q;
      word_d     = word_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               n_d        = n_clamped;
               word_cnt_d = '0;
               byte_cnt_d = '0;
               word_d     = '0;
               state_d    = (n_clamped == 11'd0) ? StDone : StLoad;
            end
         end
         StLoad: begin
            if (byte_fire) begin
               // Shifting in at the bottom leaves the first byte in [31:24].
               word_d     = {word_q[23:0], byte_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  state_d = StWrite;
               end
            end
         end
         StWrite: begin
            if (words_written == n_q) begin
               // Counter is left at the last index so it can never wrap past 1023.
               state_d = StDone;
            end else begin
               state_d    = StLoad;
               word_cnt_d = word_cnt_q + 10'd1;
               byte_cnt_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      byte_ready = (state_q == StLoad);
      ena        = (state_q == StWrite);
      wena       = (state_q == StWrite);
      rena       = 1'b0;
      addr       = {22'd0, word_cnt_q};
      data_in    = word_q;
      busy       = (state_q == StLoad) || (state_q == StWrite);
      done       = (state_q == StDone);
      cpu_stall  = busy;
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver pushes every expected RAM write
// (address, word) into a queue; a negedge monitor pops and compares on each
// write pulse and checks output invariants every cycle.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [10:0] word_count;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready, ena, wena, rena, busy, done, cpu_stall;
   logic [31:0] addr, data_in;

   imem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .word_count (word_count),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .ena        (ena),
      .wena       (wena),
      .rena       (rena),
      .addr       (addr),
      .data_in    (data_in),
      .busy       (busy),
      .done       (done),
      .cpu_stall  (cpu_stall)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t exp_q[$];
   int  vpat[$];
   int  tests = 0;
   int  fails = 0;
   int  cyc = 0;
   int  last_wr_cyc = -10;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: scoreboard pop on every write, plus structural invariants.
   always @(negedge clk) begin
      if (wena === 1'b1) begin
         last_wr_cyc = cyc;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", addr, data_in);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (addr !== e.a || data_in !== e.d) begin
               fails++;
               $display("FAIL write: got addr %h data %h expected addr %h data %h",
                        addr, data_in, e.a, e.d);
            end
         end
      end
      tests++;
      if (rena !== 1'b0 || addr[31:10] !== 22'd0 || ena !== wena || cpu_stall !== busy ||
          (busy && done) || (byte_ready && wena) || ((byte_ready | wena) !== busy)) begin
         fails++;
         $display("FAIL invariant: got rdy=%b ena=%b wena=%b rena=%b busy=%b done=%b stall=%b addr=%h expected consistent outputs",
                  byte_ready, ena, wena, rena, busy, done, cpu_stall, addr);
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
      check({tag, "_ena"},        {31'd0, ena},        32'd0);
      check({tag, "_wena"},       {31'd0, wena},       32'd0);
      check({tag, "_busy"},       {31'd0, busy},       32'd0);
      check({tag, "_done"},       {31'd0, done},       32'd0);
      check({tag, "_cpu_stall"},  {31'd0, cpu_stall},  32'd0);
      check({tag, "_addr"},       addr,                32'd0);
      check({tag, "_data_in"},    data_in,             32'd0);
   endtask

   // Called at a negedge; returns at the negedge after the start edge.
   task automatic do_start(input logic [10:0] n);
      start      = 1'b1;
      word_count = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Reference model: n words (clamped to 1024) of random bytes land at 0..n-1.
   task automatic build_random(input int n, output logic [7:0] bytes[$]);
      int neff;
      bytes = {};
      neff  = (n > 1024) ? 1024 : n;
      for (int i = 0; i < neff; i++) begin
         logic [31:0] w;
         w = '0;
         for (int j = 0; j < 4; j++) begin
            logic [7:0] b;
            b = 8'($urandom);
            bytes.push_back(b);
            w = (w << 8) | {24'd0, b};
         end
         exp_q.push_back('{a: 32'(i), d: w});
      end
   endtask

   // Offers bytes at each negedge; a handshake happens at the following posedge.
   task automatic feed(input logic [7:0] bytes[$], input int bubble_pct, input int poke,
                       input bit chk_rdy);
      int idx = 0;
      int it  = 0;
      while (idx < bytes.size() && it < 20 * bytes.size() + 50) begin
         logic v;
         if (vpat.size() > 0) v = (vpat.pop_front() != 0);
         else v = ($urandom_range(99) >= 32'(bubble_pct));
         byte_valid = v;
         byte_data  = bytes[idx];
         start      = (it == poke);
         if (it == poke) word_count = 11'd5;
         if (chk_rdy) check("byte_ready_bubble", {31'd0, byte_ready}, 32'd1);
         if (v && byte_ready) idx++;
         it++;
         @(negedge clk);
      end
      byte_valid = 1'b0;
      start      = 1'b0;
      if (idx < bytes.size()) check("feed_timeout", 32'(idx), 32'(bytes.size()));
   endtask

   task automatic wait_done(input string tag, input bit chk_timing);
      int k = 0;
      while (done !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
      if (chk_timing) check({tag, "_done_latency"}, 32'(cyc - last_wr_cyc), 32'd1);
   endtask

   initial begin
      logic [7:0] bytes[$];

      rst = 1'b1; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Zero-length session: straight to DONE, nothing written, never busy.
      do_start(11'd0);
      check("n0_done", {31'd0, done}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         check("n0_busy", {31'd0, busy}, 32'd0);
         @(negedge clk);
      end

      // Directed two-word load without bubbles.
      exp_q.push_back('{a: 32'd0, d: 32'h3C01_1001});
      exp_q.push_back('{a: 32'd1, d: 32'h2021_0005});
      bytes = '{8'h3C, 8'h01, 8'h10, 8'h01, 8'h20, 8'h21, 8'h00, 8'h05};
      do_start(11'd2);
      check("n2_done_dropped", {31'd0, done}, 32'd0);
      feed(bytes, 0, -1, 1'b0);
      wait_done("n2", 1'b1);

      // Bubbles on byte_valid stall assembly but keep byte_ready high.
      exp_q.push_back('{a: 32'd0, d: 32'hAABB_CCDD});
      bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      vpat  = '{1, 0, 0, 1, 1, 0, 1};
      do_start(11'd1);
      feed(bytes, 0, -1, 1'b1);
      wait_done("bubble", 1'b1);

      // Oversized count clamps to 1024 words ending at index 1023.
      build_random(2000, bytes);
      do_start(11'd2000);
      feed(bytes, 10, -1, 1'b0);
      wait_done("clamp", 1'b1);
      check("clamp_last_addr", addr, 32'd1023);

      // Reset mid-word: word 0 written, partial word 1 dropped.
      bytes = {};
      exp_q.push_back('{a: 32'd0, d: 32'h1122_3344});
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      do_start(11'd3);
      feed(bytes, 0, -1, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("midrst");
      repeat (5) @(negedge clk);
      check("midrst_pending_writes", 32'(exp_q.size()), 32'd0);
      check("midrst_idle_busy", {31'd0, busy}, 32'd0);

      // start during LOAD is ignored; a later start from DONE restarts at 0.
      build_random(2, bytes);
      do_start(11'd2);
      feed(bytes, 20, 3, 1'b0);
      wait_done("poke", 1'b0);
      build_random(1, bytes);
      do_start(11'd1);
      check("restart_done_dropped", {31'd0, done}, 32'd0);
      check("restart_busy", {31'd0, busy}, 32'd1);
      feed(bytes, 20, -1, 1'b0);
      wait_done("restart", 1'b1);

      // Random sessions.
      for (int s = 0; s < 6; s++) begin
         int n;
         n = $urandom_range(20, 1);
         build_random(n, bytes);
         do_start(11'(n));
         feed(bytes, 30, -1, 1'b0);
         wait_done("random", 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
